// File: rtl/x68_bus_pkg.sv
// Shared types and defaults for the 68000 bus arbiter: FSM state encoding,
// owner-index width helper and default timing constants.
package x68_bus_pkg;

    typedef enum logic [1:0] {
        ARB_CPU,
        ARB_WAIT_IDLE,
        ARB_GRANT,
        ARB_OWNED
    } arb_state_t;

    localparam int ACK_TIMEOUT_DEFAULT = 16;
    localparam int CPU_MIN_DEFAULT     = 2;

    // A single master still needs a 1-bit owner index.
    function automatic int owner_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/x68_prio_pick.sv
// Combinational request picker: fixed priority (index 0 highest) or rotating
// priority starting at start_i with wrap-around.
module x68_prio_pick
    import x68_bus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int OW   = owner_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [OW-1:0]   start_i,
    input  logic            rr_en_i,
    output logic            valid_o,
    output logic [OW-1:0]   idx_o
);

    // Scan from the far end so the last hit written is the first in scan order.
    always_comb begin
        int base;
        int pos;
        valid_o = 1'b0;
        idx_o   = '0;
        base    = rr_en_i ? int'(start_i) : 0;
        pos     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = base + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (req_i[OW'(pos)]) begin
                valid_o = 1'b1;
                idx_o   = OW'(pos);
            end
        end
    end

endmodule

// File: rtl/x68_bus_arbiter.sv
// 68000 BR/BG/BGACK bus arbiter: hands the system bus from the CPU to one of
// NREQ masters, with grant timeout and a minimum CPU hold after each release.
module x68_bus_arbiter
    import x68_bus_pkg::*;
#(
    parameter int  NREQ        = 2,
    parameter int  ROUND_ROBIN = 0,
    parameter int  ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
    parameter int  CPU_MIN     = CPU_MIN_DEFAULT,
    localparam int OW          = owner_width(NREQ)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            ce_i,
    input  logic            cpu_as_n_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] bgack_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            dma_active_n_o,
    output logic [OW-1:0]   owner_o,
    output logic            ack_timeout_o
);

    arb_state_t      state_q;
    logic [NREQ-1:0] gnt_q;
    logic            dma_n_q;
    logic [OW-1:0]   owner_q;
    logic            ato_q;
    logic [3:0]      hold_q;
    logic [7:0]      cnt_q;
    logic [OW-1:0]   rr_q;
    logic [OW-1:0]   rr_d;

    logic            pick_valid;
    logic [OW-1:0]   pick_idx;

    x68_prio_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .req_i   (req_i),
        .start_i (rr_q),
        .rr_en_i (ROUND_ROBIN != 0),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // The master that just released the bus becomes lowest priority.
    always_comb begin
        rr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
    end

    // ack_timeout is a single-clk pulse, so it clears on every clk, not only on ce.
    always_ff @(posedge clk_i) begin
        ato_q <= 1'b0;
        if (reset_i) begin
            state_q <= ARB_CPU;
            gnt_q   <= '0;
            dma_n_q <= 1'b1;
            owner_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else if (ce_i) begin
            case (state_q)
                ARB_CPU: begin
                    dma_n_q <= 1'b1;
                    if (hold_q == 4'd0 && pick_valid) begin
                        owner_q <= pick_idx;
                        state_q <= ARB_WAIT_IDLE;
                    end else if (hold_q != 4'd0) begin
                        hold_q <= hold_q - 4'd1;
                    end
                end
                ARB_WAIT_IDLE: begin
                    if (!req_i[owner_q]) begin
                        state_q <= ARB_CPU;
                    end else if (cpu_as_n_i) begin
                        gnt_q   <= NREQ'(1) << owner_q;
                        cnt_q   <= '0;
                        state_q <= ARB_GRANT;
                    end
                end
                // bgack is tested first so it beats a same-tick request drop.
                ARB_GRANT: begin
                    if (bgack_i[owner_q]) begin
                        gnt_q   <= '0;
                        dma_n_q <= 1'b0;
                        state_q <= ARB_OWNED;
                    end else if (!req_i[owner_q]) begin
                        gnt_q   <= '0;
                        state_q <= ARB_CPU;
                    end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                        gnt_q   <= '0;
                        ato_q   <= 1'b1;
                        hold_q  <= 4'(CPU_MIN);
                        state_q <= ARB_CPU;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ARB_OWNED: begin
                    dma_n_q <= 1'b0;
                    if (!bgack_i[owner_q]) begin
                        dma_n_q <= 1'b1;
                        hold_q  <= 4'(CPU_MIN);
                        rr_q    <= rr_d;
                        state_q <= ARB_CPU;
                    end
                end
                default: state_q <= ARB_CPU;
            endcase
        end
    end

    assign gnt_o          = gnt_q;
    assign dma_active_n_o = dma_n_q;
    assign owner_o        = owner_q;
    assign ack_timeout_o  = ato_q;

endmodule

// File: tb/tb_x68_bus_arbiter.sv
// Scoreboard bench for x68_bus_arbiter: directed scenarios push expected output
// changes (with the ce tick they occur on); a monitor pops and compares them.
module tb_x68_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       cpu_as_n = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] bgack = 2'b00;

    logic [1:0] gnt0, gnt1;
    logic       dman0, dman1;
    logic       own0, own1;
    logic       ato0, ato1;

    typedef struct {
        int         tick;
        logic [1:0] gnt;
        logic       dman;
        logic       ato;
        logic       own;
    } ev_t;

    ev_t  evQ[$];
    int   total = 0;
    int   bad = 0;
    int   tickCnt = 0;
    logic monEn = 1'b0;
    logic sel = 1'b0;

    x68_bus_arbiter dut0 (
        .clk_i          (clk),
        .reset_i        (reset),
        .ce_i           (ce),
        .cpu_as_n_i     (cpu_as_n),
        .req_i          (req),
        .bgack_i        (bgack),
        .gnt_o          (gnt0),
        .dma_active_n_o (dman0),
        .owner_o        (own0),
        .ack_timeout_o  (ato0)
    );

    x68_bus_arbiter #(.ROUND_ROBIN(1)) dut1 (
        .clk_i          (clk),
        .reset_i        (reset),
        .ce_i           (ce),
        .cpu_as_n_i     (cpu_as_n),
        .req_i          (req),
        .bgack_i        (bgack),
        .gnt_o          (gnt1),
        .dma_active_n_o (dman1),
        .owner_o        (own1),
        .ack_timeout_o  (ato1)
    );

    always #5 clk = ~clk;

    // ce is high on every other rising edge.
    initial forever begin
        @(negedge clk);
        ce = ~ce;
    end

    initial forever begin
        @(posedge clk);
        if (ce) tickCnt++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic ceTick(input int n);
        repeat (n) begin
            do @(posedge clk); while (ce !== 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] b, input logic asN);
        req      = r;
        bgack    = b;
        cpu_as_n = asN;
    endtask

    task automatic expectAt(input int dt, input logic [1:0] g, input logic dn,
                            input logic at, input logic ow);
        ev_t e;
        e.tick = tickCnt + dt;
        e.gnt  = g;
        e.dman = dn;
        e.ato  = at;
        e.own  = ow;
        evQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reset is checked one clk after assertion, then released and realigned to ce.
    task automatic doReset();
        monEn = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset gnt0", int'(gnt0), 0);
        checkOutput("reset dman0", int'(dman0), 1);
        checkOutput("reset owner0", int'(own0), 0);
        checkOutput("reset ato0", int'(ato0), 0);
        checkOutput("reset gnt1", int'(gnt1), 0);
        checkOutput("reset dman1", int'(dman1), 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ceTick(1);
        monEn = 1'b1;
    endtask

    // Monitor: every change of the watched DUT's outputs consumes one expected event.
    initial begin
        logic [4:0] cur;
        logic [4:0] prev;
        logic [4:0] want;
        logic       prevValid;
        logic       prevSel;
        ev_t        e;
        prevValid = 1'b0;
        prevSel   = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clk);
            cur = sel ? {gnt1, dman1, ato1, own1} : {gnt0, dman0, ato0, own0};
            if (!monEn || sel !== prevSel) prevValid = 1'b0;
            prevSel = sel;
            if (monEn) begin
                if (prevValid && cur !== prev) begin
                    total++;
                    if (evQ.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected change: got tick=%0d gnt=%b dman=%b ato=%b owner=%b, expected no change",
                                 tickCnt, cur[4:3], cur[2], cur[1], cur[0]);
                    end else begin
                        e    = evQ.pop_front();
                        want = {e.gnt, e.dman, e.ato, e.own};
                        if (cur !== want || tickCnt != e.tick) begin
                            bad++;
                            $display("[TB] FAIL event: got tick=%0d gnt=%b dman=%b ato=%b owner=%b, expected tick=%0d gnt=%b dman=%b ato=%b owner=%b",
                                     tickCnt, cur[4:3], cur[2], cur[1], cur[0],
                                     e.tick, e.gnt, e.dman, e.ato, e.own);
                        end
                    end
                end
                prev      = cur;
                prevValid = 1'b1;
            end
        end
    end

    initial begin
        doReset();

        // Fixed priority, both requesting; master 1 served after the CPU hold.
        applyStimulus(2'b11, 2'b00, 1'b1);
        expectAt(2, 2'b01, 1'b1, 1'b0, 1'b0);
        ceTick(2);
        applyStimulus(2'b11, 2'b01, 1'b1);
        expectAt(1, 2'b00, 1'b0, 1'b0, 1'b0);
        ceTick(3);
        applyStimulus(2'b10, 2'b00, 1'b1);
        expectAt(1, 2'b00, 1'b1, 1'b0, 1'b0);
        expectAt(4, 2'b00, 1'b1, 1'b0, 1'b1);
        expectAt(5, 2'b10, 1'b1, 1'b0, 1'b1);
        ceTick(5);
        applyStimulus(2'b10, 2'b10, 1'b1);
        expectAt(1, 2'b00, 1'b0, 1'b0, 1'b1);
        ceTick(1);
        applyStimulus(2'b00, 2'b00, 1'b1);
        expectAt(1, 2'b00, 1'b1, 1'b0, 1'b1);
        ceTick(1);
        applyStimulus(2'b00, 2'b00, 1'b1);
        doReset();

        // Grant held off by an active CPU cycle, then cancelled by request drop.
        applyStimulus(2'b01, 2'b00, 1'b0);
        ceTick(5);
        applyStimulus(2'b01, 2'b00, 1'b1);
        expectAt(1, 2'b01, 1'b1, 1'b0, 1'b0);
        ceTick(1);
        applyStimulus(2'b00, 2'b00, 1'b1);
        expectAt(1, 2'b00, 1'b1, 1'b0, 1'b0);
        ceTick(2);
        doReset();

        // Unacknowledged grant: 16 ticks of gnt, then a one-clk timeout pulse.
        applyStimulus(2'b10, 2'b00, 1'b1);
        expectAt(1, 2'b00, 1'b1, 1'b0, 1'b1);
        expectAt(2, 2'b10, 1'b1, 1'b0, 1'b1);
        expectAt(18, 2'b00, 1'b1, 1'b1, 1'b1);
        expectAt(18, 2'b00, 1'b1, 1'b0, 1'b1);
        ceTick(18);
        applyStimulus(2'b00, 2'b00, 1'b1);
        ceTick(4);
        doReset();

        // Reset while owned with bgack still high; no regrant without a request.
        applyStimulus(2'b01, 2'b00, 1'b1);
        expectAt(2, 2'b01, 1'b1, 1'b0, 1'b0);
        ceTick(2);
        applyStimulus(2'b01, 2'b01, 1'b1);
        expectAt(1, 2'b00, 1'b0, 1'b0, 1'b0);
        ceTick(2);
        applyStimulus(2'b00, 2'b01, 1'b1);
        doReset();
        ceTick(4);
        applyStimulus(2'b01, 2'b01, 1'b1);
        expectAt(2, 2'b01, 1'b1, 1'b0, 1'b0);
        expectAt(3, 2'b00, 1'b0, 1'b0, 1'b0);
        ceTick(3);
        applyStimulus(2'b00, 2'b00, 1'b1);
        expectAt(1, 2'b00, 1'b1, 1'b0, 1'b0);
        ceTick(1);
        applyStimulus(2'b00, 2'b00, 1'b1);
        doReset();

        // Request drop coincides with bgack: ownership wins, no cancel or timeout.
        applyStimulus(2'b01, 2'b00, 1'b1);
        expectAt(2, 2'b01, 1'b1, 1'b0, 1'b0);
        ceTick(2);
        applyStimulus(2'b00, 2'b01, 1'b1);
        expectAt(1, 2'b00, 1'b0, 1'b0, 1'b0);
        ceTick(3);
        applyStimulus(2'b00, 2'b00, 1'b1);
        expectAt(1, 2'b00, 1'b1, 1'b0, 1'b0);
        ceTick(1);
        doReset();

        // Rotating priority with both masters requesting: owners 0,1,0,1.
        sel = 1'b1;
        doReset();
        applyStimulus(2'b11, 2'b00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            int         who;
            int         pd;
            logic [1:0] oneHot;
            who    = k % 2;
            pd     = (k == 0) ? 1 : 3;
            oneHot = (who == 0) ? 2'b01 : 2'b10;
            if (k > 0) expectAt(pd, 2'b00, 1'b1, 1'b0, 1'(who));
            expectAt(pd + 1, oneHot, 1'b1, 1'b0, 1'(who));
            ceTick(pd + 1);
            applyStimulus(2'b11, oneHot, 1'b1);
            expectAt(1, 2'b00, 1'b0, 1'b0, 1'(who));
            ceTick(2);
            applyStimulus(2'b11, 2'b00, 1'b1);
            expectAt(1, 2'b00, 1'b1, 1'b0, 1'(who));
            ceTick(1);
        end
        applyStimulus(2'b00, 2'b00, 1'b1);
        ceTick(3);

        checkOutput("pending events", evQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/x68_bus_arbiter.md
Name: x68_bus_arbiter

Overview:
- Sequences ownership of the 68000 system bus between the CPU and up to NREQ bus masters (DMAC, expansion-slot masters).
- Uses the 68000 BR/BG/BGACK protocol, with active-high request/grant/ack per master.
- Generates dma_active_n, which gates the CPU clock enable and DTACK in the CPU wrapper.
- Sits between the DMAC/expansion request lines and the CPU wrapper. All decisions are made on the phi2 clock-enable tick.

Parameters:
- NREQ, 2: number of requesting bus masters (1..4).
- ROUND_ROBIN, 0: 0 = fixed priority with index 0 highest; 1 = rotating priority, where the last owner becomes lowest priority.
- ACK_TIMEOUT, 16: number of ce ticks a grant may remain unacknowledged before it is withdrawn (2..255).
- CPU_MIN, 2: minimum number of ce ticks the CPU keeps the bus after a release before a new grant (0..15).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- ce, in, 1: phi2 clock enable. All state changes occur only on clk edges with ce=1.
- cpu_as_n, in, 1: registered CPU address strobe. High means no CPU bus cycle is in progress.
- req, in, NREQ: bus request per master, active high, level.
- bgack, in, NREQ: bus-grant-acknowledge per master, active high, level.
- gnt, out, NREQ: bus grant per master, one-hot or zero, registered.
- dma_active_n, out, 1: low while a master owns the bus, registered.
- owner, out, OW = max(1, clog2(NREQ)): index of the current or pending winner. Valid when state != CPU.
- ack_timeout, out, 1: one-clk pulse when a grant is withdrawn because of timeout.

Behaviour:
- Reset values: gnt=0, dma_active_n=1, owner=0, ack_timeout=0, state=CPU, hold counter=0 (a grant is allowed immediately after reset), rr pointer=0, timeout counter=0.
- A reset mid-operation aborts any grant or ownership on the same edge. bgack is ignored until the next request.

State CPU:
- dma_active_n=1.
- If hold=0 and any req bit is set: winner = priority pick, latch owner, go to WAIT_IDLE.
- Otherwise, if hold>0: decrement hold.

State WAIT_IDLE:
- If req[owner]=0: go to CPU (request withdrawn).
- Else if cpu_as_n=1: gnt[owner]<=1, clear timeout counter, go to GRANT.
- Otherwise stay. The grant is never issued during an active CPU cycle.

State GRANT:
- If bgack[owner]=1: gnt<=0, dma_active_n<=0, go to OWNED.
- Else if req[owner]=0: gnt<=0, go to CPU (cancel).
- Else if the timeout counter reaches ACK_TIMEOUT-1: gnt<=0, pulse ack_timeout for one clk, go to CPU with hold=CPU_MIN.
- Otherwise increment the counter.
- Simultaneous bgack and req drop: bgack wins.

State OWNED:
- dma_active_n=0.
- When bgack[owner]=0: dma_active_n<=1, hold<=CPU_MIN, rr pointer<=owner+1 mod NREQ, go to CPU.
- req level is ignored while owned. Other masters' requests are queued; they are not granted.

Priority pick:
- Fixed: lowest set index.
- Round-robin: first set bit scanning upward from the rr pointer, with wrap-around.
- With NREQ=1 the pick is trivial and owner=0.

Other rules:
- bgack from a non-owner is ignored.
- Latency with an idle bus and hold=0: req seen at ce tick k gives gnt=1 after tick k+1. bgack seen at tick m gives dma_active_n=0 after tick m.

Decomposition:
- Package x68_bus_pkg holds:
  - the state enum arb_state_t {ARB_CPU, ARB_WAIT_IDLE, ARB_GRANT, ARB_OWNED};
  - the localparam function for owner width;
  - the default ACK_TIMEOUT and CPU_MIN constants.
- One sub-module, x68_prio_pick: a combinational priority/rotating picker. Inputs: req vector, start pointer, rr enable. Outputs: valid and index.

Test Plan:
- Fixed priority, req=2'b11 at the same ce with cpu_as_n=1: owner=0, gnt=01 after 2 ce ticks. bgack=01 gives gnt=00 and dma_active_n=0. Drop bgack: dma_active_n=1, then after CPU_MIN=2 ticks gnt=10.
- req[0]=1 while cpu_as_n=0 for 5 ticks: gnt stays 0 throughout. cpu_as_n goes to 1: gnt=01 on the next ce tick.
- req[1]=1 with bgack never asserted, ACK_TIMEOUT=16: gnt[1] high for exactly 16 ce ticks, then gnt=0, ack_timeout pulses one clk, and dma_active_n stays 1 throughout.
- ROUND_ROBIN=1, both masters requesting continuously through 4 complete grant/ack/release cycles: owner sequence 0,1,0,1.
- Reset asserted during OWNED with bgack=01 still high: the next clk gives gnt=0, dma_active_n=1, state CPU. No re-grant until req is sampled again.
- req[0] drops in GRANT on the same ce tick bgack[0] rises: goes to OWNED with dma_active_n=0. No cancel and no timeout pulse.
